// File: rtl/flash_cache_arbiter.sv
// Two-requester arbiter for the flash cache read port.
// A grant is held until the owner's read completes or is abandoned. One
// RELEASE cycle then forces the cache inputs low before re-arbitration.
module flash_cache_arbiter #(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter logic [31:0] IDLE_DATA   = 32'hFFFFFFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  // port 0 (typically the Wishbone flash interface)
  input  logic        r0_readEnable,
  input  logic [23:0] r0_address,
  input  logic [3:0]  r0_byteSelect,
  output logic [31:0] r0_dataRead,
  output logic        r0_busy,
  // port 1 (typically core instruction fetch)
  input  logic        r1_readEnable,
  input  logic [23:0] r1_address,
  input  logic [3:0]  r1_byteSelect,
  output logic [31:0] r1_dataRead,
  output logic        r1_busy,
  // shared cache read port
  output logic        flashCache_readEnable,
  output logic [23:0] flashCache_address,
  output logic [3:0]  flashCache_byteSelect,
  input  logic [31:0] flashCache_dataRead,
  input  logic        flashCache_busy,
  // status
  output logic [1:0]  owner
);

  localparam int unsigned ADDR_W  = 24;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned OWNER_W = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN0    = 2'd1,
    OWN1    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 last_owner_q, last_owner_d;
  logic [OWNER_W-1:0]   owner_d;

  // State, last-owner and owner-status registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      owner        <= OWNER_W'(0);
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner        <= owner_d;
    end
  end

  // Next-state: arbitration in IDLE, release on completion or abandonment
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (r0_readEnable && r1_readEnable) begin
          // Tie: round-robin hands the grant to whoever did not own last
          if (ROUND_ROBIN && !last_owner_q) begin
            state_d      = OWN1;
            last_owner_d = 1'b1;
          end else begin
            state_d      = OWN0;
            last_owner_d = 1'b0;
          end
        end else if (r0_readEnable) begin
          state_d      = OWN0;
          last_owner_d = 1'b0;
        end else if (r1_readEnable) begin
          state_d      = OWN1;
          last_owner_d = 1'b1;
        end
      end
      OWN0: begin
        if (!r0_readEnable || !flashCache_busy) state_d = RELEASE;
      end
      OWN1: begin
        if (!r1_readEnable || !flashCache_busy) state_d = RELEASE;
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner status follows the state being entered so it is registered
  always_comb begin
    owner_d = OWNER_W'(0);
    if (state_d == OWN0) owner_d = 2'b01;
    if (state_d == OWN1) owner_d = 2'b10;
  end

  // Data path: pass-through for the owner, idle levels for everyone else
  always_comb begin
    flashCache_readEnable = 1'b0;
    flashCache_address    = ADDR_W'(0);
    flashCache_byteSelect = SEL_W'(0);
    r0_busy               = 1'b1;
    r1_busy               = 1'b1;
    r0_dataRead           = IDLE_DATA;
    r1_dataRead           = IDLE_DATA;
    unique case (state_q)
      OWN0: begin
        flashCache_readEnable = r0_readEnable;
        flashCache_address    = r0_address;
        flashCache_byteSelect = r0_byteSelect;
        r0_busy               = flashCache_busy;
        r0_dataRead           = flashCache_dataRead;
      end
      OWN1: begin
        flashCache_readEnable = r1_readEnable;
        flashCache_address    = r1_address;
        flashCache_byteSelect = r1_byteSelect;
        r1_busy               = flashCache_busy;
        r1_dataRead           = flashCache_dataRead;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_flash_cache_arbiter.sv
// Directed bench: round-robin (a_*) and fixed-priority (b_*) arbiters
// share one set of requester and cache stimulus.
module tb_flash_cache_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_re, r1_re, fc_busy;
  logic [23:0] r0_addr, r1_addr;
  logic [3:0]  r0_sel, r1_sel;
  logic [31:0] fc_data;

  logic [31:0] a_r0_data, a_r1_data, b_r0_data, b_r1_data;
  logic        a_r0_busy, a_r1_busy, b_r0_busy, b_r1_busy;
  logic        a_fc_re, b_fc_re;
  logic [23:0] a_fc_addr, b_fc_addr;
  logic [3:0]  a_fc_sel, b_fc_sel;
  logic [1:0]  a_owner, b_owner;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  flash_cache_arbiter #(.ROUND_ROBIN(1'b1), .IDLE_DATA(32'hFFFFFFFF)) dut_rr (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .r0_readEnable(r0_re), .r0_address(r0_addr), .r0_byteSelect(r0_sel),
    .r0_dataRead(a_r0_data), .r0_busy(a_r0_busy),
    .r1_readEnable(r1_re), .r1_address(r1_addr), .r1_byteSelect(r1_sel),
    .r1_dataRead(a_r1_data), .r1_busy(a_r1_busy),
    .flashCache_readEnable(a_fc_re), .flashCache_address(a_fc_addr),
    .flashCache_byteSelect(a_fc_sel), .flashCache_dataRead(fc_data),
    .flashCache_busy(fc_busy), .owner(a_owner)
  );

  flash_cache_arbiter #(.ROUND_ROBIN(1'b0), .IDLE_DATA(32'hFFFFFFFF)) dut_fp (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .r0_readEnable(r0_re), .r0_address(r0_addr), .r0_byteSelect(r0_sel),
    .r0_dataRead(b_r0_data), .r0_busy(b_r0_busy),
    .r1_readEnable(r1_re), .r1_address(r1_addr), .r1_byteSelect(r1_sel),
    .r1_dataRead(b_r1_data), .r1_busy(b_r1_busy),
    .flashCache_readEnable(b_fc_re), .flashCache_address(b_fc_addr),
    .flashCache_byteSelect(b_fc_sel), .flashCache_dataRead(fc_data),
    .flashCache_busy(fc_busy), .owner(b_owner)
  );

  // Single comparison point: counts and reports
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Move to the next cycle; inputs are then driven at posedge+1
  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before checking
  task automatic settle();
    #2;
  endtask

  // Two reset cycles, check reset levels, release reset for "cycle 0"
  task automatic do_reset();
    rst = 1'b1;
    r0_re = 1'b0; r1_re = 1'b0; fc_busy = 1'b1; fc_data = 32'h0;
    r0_addr = 24'h0; r1_addr = 24'h0; r0_sel = 4'h0; r1_sel = 4'h0;
    adv();
    adv();
    settle();
    check_val("rst_owner",  32'(a_owner),   32'h0);
    check_val("rst_fc_re",  32'(a_fc_re),   32'h0);
    check_val("rst_fc_adr", 32'(a_fc_addr), 32'h0);
    check_val("rst_fc_sel", 32'(a_fc_sel),  32'h0);
    check_val("rst_busy",   32'({a_r0_busy, a_r1_busy}), 32'h3);
    check_val("rst_data0",  a_r0_data, 32'hFFFFFFFF);
    check_val("rst_data1",  a_r1_data, 32'hFFFFFFFF);
    adv();
    rst = 1'b0;
  endtask

  initial begin
    // ---- Single requester, 3 busy cycles, then same-port re-grant at C+3
    do_reset();
    r0_re = 1'b1; r0_addr = 24'h000100; r0_sel = 4'hF; fc_busy = 1'b1;  // cycle 0
    settle();
    check_val("c0_fc_re", 32'(a_fc_re), 32'h0);
    adv(); settle();                                                       // cycle 1
    check_val("c1_fc_re",  32'(a_fc_re),   32'h1);
    check_val("c1_owner",  32'(a_owner),   32'h1);
    check_val("c1_fc_adr", 32'(a_fc_addr), 32'h000100);
    check_val("c1_fc_sel", 32'(a_fc_sel),  32'hF);
    check_val("c1_r0busy", 32'(a_r0_busy), 32'h1);
    adv(); adv();                                                          // cycle 3
    adv(); fc_busy = 1'b0; fc_data = 32'hDEADBEEF; settle();               // cycle 4
    check_val("c4_r0busy", 32'(a_r0_busy), 32'h0);
    check_val("c4_r0data", a_r0_data, 32'hDEADBEEF);
    adv(); fc_busy = 1'b1; settle();                                       // cycle 5
    check_val("c5_rel_re",  32'(a_fc_re),  32'h0);
    check_val("c5_rel_own", 32'(a_owner),  32'h0);
    check_val("c5_rel_bsy", 32'(a_r0_busy), 32'h1);
    adv(); settle();                                                       // cycle 6
    check_val("c6_idle_re",  32'(a_fc_re), 32'h0);
    check_val("c6_idle_own", 32'(a_owner), 32'h0);
    adv(); fc_busy = 1'b0; settle();                                       // cycle 7
    check_val("c7_regrant", 32'(a_owner), 32'h1);
    adv(); r0_re = 1'b0; settle();                                         // cycle 8
    check_val("c8_rel", 32'(a_owner), 32'h0);

    // ---- Contention: RR alternates, fixed priority keeps port 0
    do_reset();
    r0_re = 1'b1; r1_re = 1'b1; r0_addr = 24'h000010; r1_addr = 24'h000020;
    r0_sel = 4'h3; r1_sel = 4'hC; fc_busy = 1'b0; fc_data = 32'h11111111;
    adv(); settle();                                                       // cycle 1
    check_val("k1_rr_own", 32'(a_owner), 32'h1);
    check_val("k1_fp_own", 32'(b_owner), 32'h1);
    check_val("k1_r1busy", 32'(a_r1_busy), 32'h1);
    check_val("k1_r1data", a_r1_data, 32'hFFFFFFFF);
    check_val("k1_r0data", a_r0_data, 32'h11111111);
    adv(); settle();                                                       // cycle 2
    check_val("k2_rr_rel", 32'(a_owner), 32'h0);
    adv(); adv(); settle();                                                // cycle 4
    check_val("k4_rr_own", 32'(a_owner),   32'h2);
    check_val("k4_rr_adr", 32'(a_fc_addr), 32'h000020);
    check_val("k4_rr_r0b", 32'(a_r0_busy), 32'h1);
    check_val("k4_rr_r0d", a_r0_data, 32'hFFFFFFFF);
    check_val("k4_fp_own", 32'(b_owner),   32'h1);
    adv(); adv(); adv(); settle();                                         // cycle 7
    check_val("k7_rr_own", 32'(a_owner), 32'h1);
    check_val("k7_fp_own", 32'(b_owner), 32'h1);
    adv(); adv(); r0_re = 1'b0; settle();                                  // cycle 9 (IDLE)
    adv(); settle();                                                       // cycle 10
    check_val("k10_fp_own", 32'(b_owner), 32'h2);
    check_val("k10_fp_adr", 32'(b_fc_addr), 32'h000020);
    adv(); r1_re = 1'b0;

    // ---- Abandonment with a pending port 0 request
    do_reset();
    r1_re = 1'b1; r1_addr = 24'h00ABCD; r1_sel = 4'h1; fc_busy = 1'b1;
    r0_addr = 24'h000400; r0_sel = 4'h2;
    adv(); settle();                                                       // cycle 1
    check_val("a1_own", 32'(a_owner), 32'h2);
    adv(); r0_re = 1'b1; settle();                                         // cycle 2
    check_val("a2_own", 32'(a_owner), 32'h2);
    adv(); r1_re = 1'b0; settle();                                         // cycle 3
    check_val("a3_fc_re", 32'(a_fc_re), 32'h0);
    adv(); settle();                                                       // cycle 4
    check_val("a4_rel_own", 32'(a_owner),   32'h0);
    check_val("a4_r1data",  a_r1_data,      32'hFFFFFFFF);
    adv(); settle();                                                       // cycle 5
    check_val("a5_idle_own", 32'(a_owner), 32'h0);
    adv(); fc_busy = 1'b0; settle();                                       // cycle 6
    check_val("a6_own",    32'(a_owner),   32'h1);
    check_val("a6_fc_adr", 32'(a_fc_addr), 32'h000400);
    adv(); r0_re = 1'b0;

    // ---- Reset mid-transaction, then contended grant and address isolation
    do_reset();
    r0_re = 1'b1; r0_addr = 24'h000100; r0_sel = 4'h5; fc_busy = 1'b1;
    adv(); settle();                                                       // cycle 1
    check_val("m1_own", 32'(a_owner), 32'h1);
    adv(); rst = 1'b1; r1_re = 1'b1; r1_addr = 24'h777777; r1_sel = 4'hA;  // cycle 2
    adv(); rst = 1'b0; settle();                                           // cycle 3
    check_val("m3_own",    32'(a_owner),   32'h0);
    check_val("m3_fc_re",  32'(a_fc_re),   32'h0);
    check_val("m3_fc_adr", 32'(a_fc_addr), 32'h0);
    check_val("m3_busy",   32'({a_r0_busy, a_r1_busy}), 32'h3);
    adv(); settle();                                                       // cycle 4
    check_val("m4_rr_own", 32'(a_owner),   32'h1);
    check_val("m4_fc_adr", 32'(a_fc_addr), 32'h000100);
    for (int i = 0; i < 2; i++) begin                                      // cycles 5,6
      adv();
      r1_addr = 24'(24'h123450 + i); r1_sel = 4'(4'h9 + i);
      settle();
      check_val("iso_adr", 32'(a_fc_addr), 32'h000100);
      check_val("iso_sel", 32'(a_fc_sel),  32'h5);
    end
    adv(); fc_busy = 1'b0; r1_addr = 24'hFEDCBA; r1_sel = 4'hE; settle(); // cycle 7
    check_val("iso_done_adr", 32'(a_fc_addr), 32'h000100);
    check_val("iso_done_bsy", 32'(a_r0_busy), 32'h0);
    adv(); r0_re = 1'b0; settle();                                         // cycle 8
    check_val("iso_rel_adr", 32'(a_fc_addr), 32'h0);
    check_val("iso_rel_sel", 32'(a_fc_sel),  32'h0);
    adv(); r1_re = 1'b0;
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
